fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the 5-stage RV32I core. It holds the PC and issues single-outstanding requests to instruction memory over a request/response handshake. Returned instructions are presented to decode through the IF/ID register. The block consumes PCwrite and IF_IDwrite from the load-use hazard detector and branch_taken/branch_target from EX, and applies stall, flush and redirect.

---
 rtl/fetch_stage.sv | 105 ++++++++++
 tb/tb_fetch_stage.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register.
// Holds the PC, keeps at most one request outstanding to instruction memory,
// and buffers a response that arrives while decode is stalled.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCwrite,
    input  logic        IF_IDwrite,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_instr,
    output logic        IF_ID_valid
);

    // FETCH: idle, WAIT: response will be kept, DROP: response will be discarded
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] fetch_pc;
    logic        hold_valid;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    logic        accept;
    logic        kept_rsp;

    assign imem_addr = pc;
    assign accept    = imem_req & imem_ready;
    assign kept_rsp  = (state == WAIT) & imem_rvalid;

    // Issue a fetch when idle, or back-to-back when the pending response can go straight to IF/ID
    always_comb begin
        imem_req = !rst && !branch_taken && PCwrite && !hold_valid &&
                   ((state == FETCH) || ((state == WAIT) && imem_rvalid && IF_IDwrite));
    end

    // Request FSM and PC: a redirect wins over everything and orphans any in-flight response
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            fetch_pc <= RESET_PC;
        end else if (branch_taken) begin
            pc    <= branch_target;
            state <= ((state != FETCH) && !imem_rvalid) ? DROP : FETCH;
        end else begin
            if (accept) begin
                fetch_pc <= pc;
                pc       <= pc + 32'd4;
                state    <= WAIT;
            end else if ((state != FETCH) && imem_rvalid) begin
                state <= FETCH;
            end
        end
    end

    // IF/ID register and one-entry hold buffer for responses that arrive during a decode stall
    always_ff @(posedge clk) begin
        if (rst) begin
            IF_ID_pc    <= 32'h0000_0000;
            IF_ID_instr <= NOP_INSTR;
            IF_ID_valid <= 1'b0;
            hold_valid  <= 1'b0;
            hold_pc     <= 32'h0000_0000;
            hold_instr  <= NOP_INSTR;
        end else if (branch_taken) begin
            IF_ID_instr <= NOP_INSTR;
            IF_ID_valid <= 1'b0;
            hold_valid  <= 1'b0;
        end else begin
            if (IF_IDwrite && hold_valid) begin
                IF_ID_pc    <= hold_pc;
                IF_ID_instr <= hold_instr;
                IF_ID_valid <= 1'b1;
                hold_valid  <= 1'b0;
            end else if (IF_IDwrite && kept_rsp) begin
                IF_ID_pc    <= fetch_pc;
                IF_ID_instr <= imem_rdata;
                IF_ID_valid <= 1'b1;
            end else if (IF_IDwrite) begin
                IF_ID_instr <= NOP_INSTR;
                IF_ID_valid <= 1'b0;
            end
            if (kept_rsp && (!IF_IDwrite || hold_valid)) begin
                hold_pc    <= fetch_pc;
                hold_instr <= imem_rdata;
                hold_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized stall/redirect/memory timing.
// Accepted fetches are queued in program order; a monitor pops them as decode
// receives instructions and squashes the queue on redirect or reset.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] KEY       = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        PCwrite;
    logic        IF_IDwrite;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_instr;
    logic        IF_ID_valid;

    int n_vec  = 0;
    int n_fail = 0;

    // memory model knobs: ready_mode 0=random 1=always 2=never; lat_mode 0=random 1..4, else fixed
    int          ready_mode;
    int          lat_mode;
    logic        mem_pending;
    logic [31:0] mem_addr;
    int          mem_wait;

    // reference model: program-order queue of accepted fetches and IF/ID contents
    logic [31:0] exp_q[$];
    logic [31:0] exp_fetch_addr;
    logic        m_valid;
    logic [31:0] m_pc;
    int          idle_cycles;

    fetch_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .PCwrite       (PCwrite),
        .IF_IDwrite    (IF_IDwrite),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .IF_ID_pc      (IF_ID_pc),
        .IF_ID_instr   (IF_ID_instr),
        .IF_ID_valid   (IF_ID_valid)
    );

    // core clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, want %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkIfId(input string name, input logic v, input logic [31:0] p);
        checkOutput({name, "_valid"}, {31'd0, IF_ID_valid}, {31'd0, v});
        checkOutput({name, "_pc"}, IF_ID_pc, p);
        checkOutput({name, "_instr"}, IF_ID_instr, v ? (p ^ KEY) : NOP_INSTR);
    endtask

    task automatic checkReq(input string name, input logic r, input logic [31:0] a);
        checkOutput({name, "_req"}, {31'd0, imem_req}, {31'd0, r});
        if (r) checkOutput({name, "_addr"}, imem_addr, a);
    endtask

    // drive inputs at the falling edge, return 3 time units later with combinational outputs settled
    task automatic applyStimulus(input logic r, input logic pw, input logic iw,
                                 input logic bt, input logic [31:0] tgt);
        @(negedge clk);
        rst           = r;
        PCwrite       = pw;
        IF_IDwrite    = iw;
        branch_taken  = bt;
        branch_target = tgt;
        #3;
    endtask

    task automatic postEdge();
        @(posedge clk);
        #1;
    endtask

    // instruction memory: one response per accepted request, rdata = addr ^ KEY
    initial begin
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        mem_pending = 1'b0;
        mem_addr    = 32'h0;
        mem_wait    = 0;
        forever begin
            @(negedge clk);
            if (mem_pending && mem_wait == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_addr ^ KEY;
                mem_pending = 1'b0;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
                if (mem_pending) mem_wait--;
            end
            case (ready_mode)
                1:       imem_ready = 1'b1;
                2:       imem_ready = 1'b0;
                default: imem_ready = ($urandom_range(0, 9) < 7);
            endcase
            #3;
            if (imem_req && imem_ready && !rst) begin
                checkOutput("single_outstanding", {31'd0, mem_pending}, 32'd0);
                mem_pending = 1'b1;
                mem_addr    = imem_addr;
                mem_wait    = ((lat_mode == 0) ? int'($urandom_range(1, 4)) : lat_mode) - 1;
            end
        end
    end

    // scoreboard monitor: request rules before the edge, IF/ID contents after it
    initial begin : monitor_proc
        logic        s_rst;
        logic        s_pw;
        logic        s_iw;
        logic        s_bt;
        logic [31:0] s_tgt;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #3;
            s_rst = rst;
            s_pw  = PCwrite;
            s_iw  = IF_IDwrite;
            s_bt  = branch_taken;
            s_tgt = branch_target;
            if (s_rst)      checkOutput("req_in_reset", {31'd0, imem_req}, 32'd0);
            else if (s_bt)  checkOutput("req_on_redirect", {31'd0, imem_req}, 32'd0);
            else if (!s_pw) checkOutput("req_on_stall", {31'd0, imem_req}, 32'd0);
            if (!s_rst && imem_req && imem_ready) begin
                checkOutput("fetch_addr", imem_addr, exp_fetch_addr);
                exp_q.push_back(exp_fetch_addr);
                exp_fetch_addr = exp_fetch_addr + 32'd4;
            end
            @(posedge clk);
            #1;
            if (s_rst) begin
                checkOutput("rst_valid", {31'd0, IF_ID_valid}, 32'd0);
                checkOutput("rst_instr", IF_ID_instr, NOP_INSTR);
                checkOutput("rst_pc", IF_ID_pc, 32'd0);
                exp_q.delete();
                exp_fetch_addr = RESET_PC;
                m_valid        = 1'b0;
                m_pc           = 32'd0;
                idle_cycles    = 0;
            end else if (s_bt) begin
                checkOutput("flush_valid", {31'd0, IF_ID_valid}, 32'd0);
                checkOutput("flush_instr", IF_ID_instr, NOP_INSTR);
                checkOutput("flush_pc", IF_ID_pc, m_pc);
                exp_q.delete();
                exp_fetch_addr = s_tgt;
                m_valid        = 1'b0;
                idle_cycles++;
            end else if (s_iw) begin
                if (IF_ID_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("[TB] FAIL spurious_delivery: got pc %h, want no instruction at %0t", IF_ID_pc, $time);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("deliver_pc", IF_ID_pc, e);
                        checkOutput("deliver_instr", IF_ID_instr, e ^ KEY);
                        m_pc = e;
                    end
                    m_valid     = 1'b1;
                    idle_cycles = 0;
                end else begin
                    checkOutput("bubble_instr", IF_ID_instr, NOP_INSTR);
                    checkOutput("bubble_pc", IF_ID_pc, m_pc);
                    m_valid = 1'b0;
                    idle_cycles++;
                end
            end else begin
                checkOutput("hold_valid", {31'd0, IF_ID_valid}, {31'd0, m_valid});
                checkOutput("hold_pc", IF_ID_pc, m_pc);
                checkOutput("hold_instr", IF_ID_instr, m_valid ? (m_pc ^ KEY) : NOP_INSTR);
                idle_cycles++;
            end
            if (idle_cycles > 200) begin
                n_vec++;
                n_fail++;
                $display("[TB] FAIL liveness: got %0d cycles without delivery, want at most 200", idle_cycles);
                idle_cycles = 0;
            end
        end
    end

    // directed scenarios, randomized traffic, then drain and summary
    initial begin
        rst            = 1'b1;
        PCwrite        = 1'b0;
        IF_IDwrite     = 1'b0;
        branch_taken   = 1'b0;
        branch_target  = 32'h0;
        ready_mode     = 1;
        lat_mode       = 1;
        exp_fetch_addr = RESET_PC;
        m_valid        = 1'b0;
        m_pc           = 32'h0;
        idle_cycles    = 0;

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
            checkReq("reset", 1'b0, 32'h0);
            postEdge();
            checkIfId("reset", 1'b0, 32'h0);
        end

        // straight-line fetch with single-cycle memory
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            if (k == 0) checkReq("first_req", 1'b1, RESET_PC);
            postEdge();
            if (k == 0) checkIfId("startup", 1'b0, 32'h0);
            else        checkIfId("straight", 1'b1, 32'(k - 1) * 32'd4);
        end

        // load-use stall while the response for PC 16 arrives
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkReq("stall0", 1'b0, 32'h0);
        postEdge();
        checkIfId("stall0", 1'b1, 32'd12);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        checkReq("stall1", 1'b0, 32'h0);
        postEdge();
        checkIfId("stall1", 1'b1, 32'd12);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkReq("drain", 1'b0, 32'h0);
        postEdge();
        checkIfId("drain", 1'b1, 32'd16);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkReq("resume", 1'b1, 32'd20);
        postEdge();
        checkIfId("resume", 1'b0, 32'd16);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        postEdge();
        checkIfId("resume2", 1'b1, 32'd20);

        // redirect while a slow request is outstanding
        lat_mode = 3;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        postEdge();
        checkIfId("slow_issue", 1'b1, 32'd24);
        lat_mode = 1;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h100);
        checkReq("redir_wait", 1'b0, 32'h0);
        postEdge();
        checkIfId("redir_wait", 1'b0, 32'd24);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
            checkReq("drop", 1'b0, 32'h0);
            postEdge();
            checkIfId("drop", 1'b0, 32'd24);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkReq("after_drop", 1'b1, 32'h100);
        postEdge();
        checkIfId("after_drop", 1'b0, 32'd24);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        postEdge();
        checkIfId("target_fetch", 1'b1, 32'h100);

        // redirect in the same cycle as the response
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h40);
        checkReq("redir_rvalid", 1'b0, 32'h0);
        postEdge();
        checkIfId("redir_rvalid", 1'b0, 32'h100);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkReq("redir_next", 1'b1, 32'h40);
        postEdge();
        checkIfId("redir_next", 1'b0, 32'h100);
        lat_mode = 3;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        postEdge();
        checkIfId("target40", 1'b1, 32'h40);

        // reset with a request outstanding; its late response must be ignored
        lat_mode   = 1;
        ready_mode = 2;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        postEdge();
        checkIfId("midwait_rst", 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkReq("post_rst", 1'b1, RESET_PC);
        postEdge();
        checkIfId("post_rst", 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkReq("stale_rvalid", 1'b1, RESET_PC);
        postEdge();
        checkIfId("stale_rvalid", 1'b0, 32'h0);
        ready_mode = 1;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        postEdge();
        checkIfId("refetch", 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        postEdge();
        checkIfId("refetch_done", 1'b1, RESET_PC);

        // randomized stalls, redirects (including near the top of the address space) and memory timing
        ready_mode = 0;
        lat_mode   = 0;
        for (int c = 0; c < 3000; c++) begin
            logic        pw;
            logic        iw;
            logic        bt;
            logic [31:0] tgt;
            pw  = ($urandom_range(0, 7) != 0);
            iw  = ($urandom_range(0, 7) != 0);
            bt  = ($urandom_range(0, 15) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_0FFC);
            applyStimulus(1'b0, pw, iw, bt, tgt);
            postEdge();
        end

        // stop fetching and let every accepted instruction reach decode
        for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
            postEdge();
            #1;
        end
        #1;
        checkOutput("drain_queue", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
